// File: rtl/llki_mock_tss_lane_lock.sv
// Mock TSS lane lock: loads a multi-word LLKI key and XORs lanes with (MOCK_KEY ^ key); x_out/core_next 1-cycle latency.
// Key words are accepted only while llkid_key_ready is high; clear wins over a simultaneous key word.
module llki_mock_tss_lane_lock #(
   parameter int                        LANES      = 4,
   parameter int                        LANE_W     = 16,
   parameter int                        KEY_WORDS  = 2,
   parameter logic [64*KEY_WORDS-1:0]   MOCK_KEY   = '0,
   parameter bit                        GATE_START = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      next,
   output logic                      core_next,
   input  logic [LANES*LANE_W-1:0]   x_in,
   output logic [LANES*LANE_W-1:0]   x_out,
   input  logic [63:0]               llkid_key_data,
   input  logic                      llkid_key_valid,
   output logic                      llkid_key_ready,
   output logic                      llkid_key_complete,
   input  logic                      llkid_clear_key,
   output logic                      llkid_clear_key_ack,
   output logic                      key_match
);

   localparam int K     = 64*KEY_WORDS;
   localparam int CNT_W = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;
   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(KEY_WORDS-1);

   if ((K % LANE_W) != 0) begin : g_bad_lane_w
      $error("64*KEY_WORDS must be a multiple of LANE_W");
   end

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_LOAD     = 2'd1,
      ST_COMPLETE = 2'd2,
      ST_CLEAR    = 2'd3
   } state_t;

   state_t                   r_state;
   state_t                   w_nxt;
   logic [K-1:0]             r_key;
   logic [CNT_W-1:0]         r_cnt;
   logic                     r_ready;
   logic                     r_complete;
   logic                     r_ack;
   logic                     r_core_next;
   logic [LANES*LANE_W-1:0]  r_x_out;
   logic [LANES*LANE_W-1:0]  w_x_ks;
   logic                     w_accept;
   logic                     w_start_ok;

   assign w_accept = llkid_key_valid & r_ready & ~llkid_clear_key;

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         ST_IDLE, ST_LOAD: begin
            if (w_accept) begin
               w_nxt = (r_cnt == LAST_WORD) ? ST_COMPLETE : ST_LOAD;
            end
         end
         ST_COMPLETE: w_nxt = ST_COMPLETE;
         ST_CLEAR:    w_nxt = ST_IDLE;
         default:     w_nxt = ST_IDLE;
      endcase
      if (llkid_clear_key) begin
         w_nxt = ST_CLEAR;
      end
   end

   // Handshake outputs are registered from the next state so they are all low in reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_ready    <= 1'b0;
         r_complete <= 1'b0;
         r_ack      <= 1'b0;
      end else begin
         r_state    <= w_nxt;
         r_ready    <= (w_nxt == ST_IDLE) || (w_nxt == ST_LOAD);
         r_complete <= (w_nxt == ST_COMPLETE);
         r_ack      <= (w_nxt == ST_CLEAR);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_key <= '0;
         r_cnt <= '0;
      end else if (llkid_clear_key) begin
         r_key <= '0;
         r_cnt <= '0;
      end else if (w_accept) begin
         for (int k = 0; k < KEY_WORDS; k++) begin
            if (r_cnt == CNT_W'(k)) begin
               r_key[64*k +: 64] <= llkid_key_data;
            end
         end
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // Keystream wraps over the key width, so lane i starts at (i*LANE_W) mod K.
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      localparam int OFF = (i*LANE_W) % K;
      assign w_x_ks[i*LANE_W +: LANE_W] = x_in[i*LANE_W +: LANE_W]
                                        ^ MOCK_KEY[OFF +: LANE_W]
                                        ^ r_key[OFF +: LANE_W];
   end

   assign w_start_ok = GATE_START ? r_complete : 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x_out     <= '0;
         r_core_next <= 1'b0;
      end else begin
         r_x_out     <= w_x_ks;
         r_core_next <= next & w_start_ok;
      end
   end

   assign x_out               = r_x_out;
   assign core_next           = r_core_next;
   assign llkid_key_ready     = r_ready;
   assign llkid_key_complete  = r_complete;
   assign llkid_clear_key_ack = r_ack;
   assign key_match           = r_complete & (r_key == MOCK_KEY);

endmodule

// File: tb/tb_llki_mock_tss_lane_lock.sv
// Bench for llki_mock_tss_lane_lock: directed scenarios then random traffic against a behavioural model.
module tb_llki_mock_tss_lane_lock;
   localparam int          LANES  = 4;
   localparam int          LANE_W = 16;
   localparam int          KW     = 2;
   localparam logic [127:0] MK    = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
   localparam logic [63:0]  W0    = 64'hFEDC_BA98_7654_3210;
   localparam logic [63:0]  W1    = 64'h0123_4567_89AB_CDEF;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        next = 1'b0;
   logic [63:0] x_in = '0;
   logic [63:0] key_data = '0;
   logic        key_valid = 1'b0;
   logic        clear_key = 1'b0;

   logic        core_next, core_next2;
   logic [63:0] x_out, x_out2;
   logic        ready, ready2, complete, complete2, ack, ack2, key_match, key_match2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   llki_mock_tss_lane_lock #(.LANES(LANES), .LANE_W(LANE_W), .KEY_WORDS(KW),
                             .MOCK_KEY(MK), .GATE_START(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .next(next), .core_next(core_next),
      .x_in(x_in), .x_out(x_out),
      .llkid_key_data(key_data), .llkid_key_valid(key_valid), .llkid_key_ready(ready),
      .llkid_key_complete(complete), .llkid_clear_key(clear_key),
      .llkid_clear_key_ack(ack), .key_match(key_match));

   llki_mock_tss_lane_lock #(.LANES(LANES), .LANE_W(LANE_W), .KEY_WORDS(KW),
                             .MOCK_KEY(MK), .GATE_START(1'b0)) dut_ungated (
      .clk(clk), .rst_n(rst_n), .next(next), .core_next(core_next2),
      .x_in(x_in), .x_out(x_out2),
      .llkid_key_data(key_data), .llkid_key_valid(key_valid), .llkid_key_ready(ready2),
      .llkid_key_complete(complete2), .llkid_clear_key(clear_key),
      .llkid_clear_key_ack(ack2), .key_match(key_match2));

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   // Behavioural model: key words in an array-like vector, a word count and a few flags.
   logic [127:0] m_key = '0;
   logic [127:0] m_ks;
   int           m_cnt = 0;
   bit           m_ready = 0, m_complete = 0, m_ack = 0, m_core = 0, m_core2 = 0;
   logic [63:0]  m_xout = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_key = '0; m_cnt = 0; m_ready = 0; m_complete = 0; m_ack = 0;
         m_core = 0; m_core2 = 0; m_xout = '0;
      end else begin
         m_ks    = MK ^ m_key;
         m_xout  = x_in ^ m_ks[63:0];
         m_core  = next & m_complete;
         m_core2 = next;
         if (clear_key) begin
            m_key = '0; m_cnt = 0; m_complete = 0; m_ready = 0; m_ack = 1;
         end else if (m_complete) begin
            m_ack = 0;
         end else if (!m_ready) begin
            m_ready = 1; m_ack = 0;
         end else if (key_valid) begin
            m_key[64*m_cnt +: 64] = key_data;
            m_cnt++;
            if (m_cnt == KW) begin
               m_complete = 1; m_ready = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("cmp_ready", 64'(ready), 64'(m_ready));
      chk("cmp_complete", 64'(complete), 64'(m_complete));
      chk("cmp_ack", 64'(ack), 64'(m_ack));
      chk("cmp_key_match", 64'(key_match), 64'(m_complete && (m_key == MK)));
      chk("cmp_core_next", 64'(core_next), 64'(m_core));
      chk("cmp_core_next_ungated", 64'(core_next2), 64'(m_core2));
      chk("cmp_x_out", x_out, m_xout);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [63:0] a, input logic [63:0] b);
      key_valid = 1'b1; key_data = a; tick();
      key_data = b; tick();
      key_valid = 1'b0;
   endtask

   task automatic clear_pulse();
      clear_key = 1'b1; tick();
      clear_key = 1'b0; tick();
   endtask

   initial begin
      repeat (3) tick();
      chk("rst_ready", 64'(ready), 64'd0);
      chk("rst_x_out", x_out, 64'd0);
      chk("rst_core_next", 64'(core_next), 64'd0);

      rst_n = 1'b1; tick();
      chk("rel_ready", 64'(ready), 64'd1);
      chk("rel_complete", 64'(complete), 64'd0);
      chk("rel_ack", 64'(ack), 64'd0);
      chk("rel_key_match", 64'(key_match), 64'd0);
      chk("nokey_x_out", x_out, 64'hFEDC_BA98_7654_3210);

      next = 1'b1; tick(); next = 1'b0;
      chk("nokey_core_next", 64'(core_next), 64'd0);
      chk("nokey_core_next_ungated", 64'(core_next2), 64'd1);

      key_valid = 1'b1; key_data = W0; tick();
      chk("load1_complete", 64'(complete), 64'd0);
      chk("load1_ready", 64'(ready), 64'd1);
      key_data = W1; tick(); key_valid = 1'b0;
      chk("load2_complete", 64'(complete), 64'd1);
      chk("load2_key_match", 64'(key_match), 64'd1);
      chk("load2_ready", 64'(ready), 64'd0);
      x_in = 64'h1111_2222_3333_4444; tick();
      chk("match_x_out", x_out, 64'h1111_2222_3333_4444);
      next = 1'b1; tick(); next = 1'b0;
      chk("match_core_next", 64'(core_next), 64'd1);

      clear_key = 1'b1; tick(); clear_key = 1'b0;
      chk("clr_ack", 64'(ack), 64'd1);
      chk("clr_complete", 64'(complete), 64'd0);
      chk("clr_key_match", 64'(key_match), 64'd0);
      tick();
      chk("clr_ack_drop", 64'(ack), 64'd0);
      chk("clr_ready", 64'(ready), 64'd1);

      load(64'h0, W1);
      chk("bad0_complete", 64'(complete), 64'd1);
      chk("bad0_key_match", 64'(key_match), 64'd0);
      x_in = 64'h0; tick();
      chk("bad0_x_out", x_out, 64'hFEDC_BA98_7654_3210);
      next = 1'b1; tick(); next = 1'b0;
      chk("bad0_core_next", 64'(core_next), 64'd1);

      clear_pulse();
      load(W0, 64'h0);
      chk("bad1_complete", 64'(complete), 64'd1);
      chk("bad1_key_match", 64'(key_match), 64'd0);
      x_in = 64'hDEAD_BEEF_0BAD_F00D; tick();

      clear_pulse();
      key_valid = 1'b1; key_data = W0; tick();
      key_data = W1; clear_key = 1'b1; tick();
      key_valid = 1'b0; clear_key = 1'b0;
      chk("race_ack", 64'(ack), 64'd1);
      chk("race_complete", 64'(complete), 64'd0);
      tick();
      chk("race_ready", 64'(ready), 64'd1);
      chk("race_complete2", 64'(complete), 64'd0);
      load(W0, W1);
      chk("race_reload_match", 64'(key_match), 64'd1);

      clear_key = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hold_ack", 64'(ack), 64'd1);
      end
      clear_key = 1'b0; tick();
      chk("hold_ack_drop", 64'(ack), 64'd0);

      key_valid = 1'b1; key_data = W0; tick(); key_valid = 1'b0;
      rst_n = 1'b0; #1;
      chk("midrst_complete", 64'(complete), 64'd0);
      chk("midrst_ready", 64'(ready), 64'd0);
      chk("midrst_ack", 64'(ack), 64'd0);
      rst_n = 1'b1; tick();
      key_valid = 1'b1; key_data = W1; tick(); key_valid = 1'b0;
      chk("midrst_one_word", 64'(complete), 64'd0);
      clear_pulse();
      load(W0, W1);
      chk("midrst_reload_match", 64'(key_match), 64'd1);

      for (int n = 0; n < 3000; n++) begin
         x_in      = {$urandom, $urandom};
         next      = ($urandom_range(0, 3) == 0);
         key_valid = $urandom_range(0, 1) == 1;
         if ($urandom_range(0, 3) != 0) key_data = (m_cnt == 0) ? W0 : W1;
         else                           key_data = {$urandom, $urandom};
         clear_key = ($urandom_range(0, 24) == 0);
         if ($urandom_range(0, 399) == 0) begin
            rst_n = 1'b0; tick(); rst_n = 1'b1;
         end
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
